ray_sphere_discriminant: RTL and testbench

RAY_SPHERE_DISCRIMINANT -- requirements
Module: ray_sphere_discriminant

---
 rtl/ray_sphere_discriminant.sv | 117 +++++++++++
 tb/tb_ray_sphere_discriminant.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_sphere_discriminant.sv
// Ray/sphere discriminant b*b - a*(c - R_SQ) from three streamed dot products, with hit flag.
// Define RAY_HIT_COUNT_EN to add a saturating hit_count output.
module ray_sphere_discriminant #(
  parameter int              W    = 19,
  parameter logic [W-1:0]    R_SQ = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_scalar,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W+1:0] out_disc,
  output logic                  out_hit
`ifdef RAY_HIT_COUNT_EN
  ,
  output logic [15:0]           hit_count
`endif
);

  typedef enum logic [2:0] {COLLECT, MUL_BB, MUL_AC, SUB, OUT} state_t;

  state_t state, next_state;
  logic [1:0] beat;
  logic ready_en;
  logic signed [W-1:0]   a, b, c;
  logic signed [2*W-1:0] bb;
  logic signed [2*W+1:0] ac;
  logic signed [W:0]     c_adj, mul_x, mul_y;
  logic signed [2*W+1:0] prod, disc_next;
  logic accept;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en && (state == COLLECT);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;

  assign c_adj     = {c[W-1], c} - {1'b0, R_SQ};
  assign prod      = mul_x * mul_y;
  assign disc_next = {{2{bb[2*W-1]}}, bb} - ac;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      ready_en <= 1'b0;
    end else begin
      state    <= next_state;
      ready_en <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      COLLECT: if (accept && beat == 2'd2) next_state = MUL_BB;
      MUL_BB:  next_state = MUL_AC;
      MUL_AC:  next_state = SUB;
      SUB:     next_state = OUT;
      OUT:     if (out_ready) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // One multiplier: b*b in MUL_BB, a*(c - R_SQ) otherwise.
  always_comb begin
    mul_x = {a[W-1], a};
    mul_y = c_adj;
    if (state == MUL_BB) begin
      mul_x = {b[W-1], b};
      mul_y = {b[W-1], b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= 2'd0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      bb       <= '0;
      ac       <= '0;
      out_disc <= '0;
      out_hit  <= 1'b0;
    end else begin
      if (accept) begin
        unique case (beat)
          2'd0:    a <= in_scalar;
          2'd1:    b <= in_scalar;
          default: c <= in_scalar;
        endcase
        beat <= (beat == 2'd2) ? 2'd0 : beat + 2'd1;
      end
      if (state == MUL_BB) bb <= prod[2*W-1:0];
      if (state == MUL_AC) ac <= prod;
      if (state == SUB) begin
        out_disc <= disc_next;
        out_hit  <= !disc_next[2*W+1] && (a != '0);
      end
    end
  end

`ifdef RAY_HIT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (out_valid && out_ready && out_hit && hit_count != 16'hFFFF) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`else
  // Base build keeps no hit statistics.
`endif

endmodule

// File: tb/tb_ray_sphere_discriminant.sv
// Scoreboard bench for ray_sphere_discriminant: two instances (R_SQ=0 and R_SQ=4) share stimulus,
// expected results come from plain integer arithmetic on the ray scalars.
module tb_ray_sphere_discriminant;
  localparam int W  = 19;
  localparam int DW = 2*W+2;
  localparam logic [W-1:0] RSQ_A = '0;
  localparam logic [W-1:0] RSQ_B = 19'd4;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_scalar = '0;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_hit_a, out_hit_b;
  logic signed [DW-1:0] out_disc_a, out_disc_b;
`ifdef RAY_HIT_COUNT_EN
  logic [15:0] hit_count_a, hit_count_b;
`endif

  ray_sphere_discriminant #(.W(W), .R_SQ(RSQ_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_scalar(in_scalar),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_disc(out_disc_a), .out_hit(out_hit_a)
`ifdef RAY_HIT_COUNT_EN
    , .hit_count(hit_count_a)
`endif
  );

  ray_sphere_discriminant #(.W(W), .R_SQ(RSQ_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_scalar(in_scalar),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_disc(out_disc_b), .out_hit(out_hit_b)
`ifdef RAY_HIT_COUNT_EN
    , .hit_count(hit_count_b)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint d_a;
    longint d_b;
    bit     h_a;
    bit     h_b;
    int     rise;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  bit force_low = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: discriminant of |O + tD - C|^2 = r^2 in dot-product form.
  function automatic longint ref_disc(input longint a, input longint b, input longint c, input longint r);
    return b*b - a*(c - r);
  endfunction

  function automatic longint rnd_full();
    logic [W-1:0] t;
    t = W'($urandom);
    return longint'($signed(t));
  endfunction

  task automatic send_beat(input longint v, output int acc);
    int waited;
    waited = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_scalar = W'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    in_scalar = v[W-1:0];
    while (!in_ready_a && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("in_ready_timeout", 0, 1);
    acc = cyc;
  endtask

  task automatic send_ray(input longint a, input longint b, input longint c);
    int acc;
    exp_t it;
    send_beat(a, acc);
    send_beat(b, acc);
    send_beat(c, acc);
    it.d_a  = ref_disc(a, b, c, longint'(RSQ_A));
    it.d_b  = ref_disc(a, b, c, longint'(RSQ_B));
    it.h_a  = (it.d_a >= 0) && (a != 0);
    it.h_b  = (it.d_b >= 0) && (a != 0);
    it.rise = acc + 4;
    exp_q.push_back(it);
    @(negedge clk);
    in_valid  = 1'b0;
    in_scalar = W'($urandom);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || out_valid_a) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("drain_timeout", 0, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each new result and polices the OUT-state rules.
  initial begin
    bit was_valid, expect_idle;
    int hits_a, hits_b;
    exp_t cur;
    logic signed [DW-1:0] held_a;
    logic held_h;
    was_valid = 0; expect_idle = 0; hits_a = 0; hits_b = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        was_valid = 0; expect_idle = 0; hits_a = 0; hits_b = 0;
        continue;
      end
      if (expect_idle) begin
        check("in_ready_after_handshake", in_ready_a, 1);
        check("out_valid_after_handshake", out_valid_a, 0);
        expect_idle = 0;
      end
`ifdef RAY_HIT_COUNT_EN
      check("hit_count_a", hit_count_a, hits_a);
      check("hit_count_b", hit_count_b, hits_b);
`endif
      if (out_valid_a) begin
        check("in_ready_while_out", in_ready_a, 0);
        if (!was_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("out_disc_a", out_disc_a, cur.d_a);
            check("out_hit_a", out_hit_a, cur.h_a);
            check("out_valid_b", out_valid_b, 1);
            check("out_disc_b", out_disc_b, cur.d_b);
            check("out_hit_b", out_hit_b, cur.h_b);
            check("latency", cyc, cur.rise);
          end
          held_a = out_disc_a;
          held_h = out_hit_a;
        end else begin
          check("disc_stable", out_disc_a, held_a);
          check("hit_stable", out_hit_a, held_h);
        end
        if (out_ready) begin
          expect_idle = 1;
          if (cur.h_a && hits_a < 16'hFFFF) hits_a++;
          if (cur.h_b && hits_b < 16'hFFFF) hits_b++;
        end
      end
      was_valid = out_valid_a && !out_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_disc", out_disc_a, 0);
    check("rst_out_hit", out_hit_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready_a, 0);
    @(posedge clk);
    #1;
    check("in_ready_first_edge", in_ready_a, 1);

    send_ray(1, 2, 3);
    send_ray(1, 1, 5);
    send_ray(1, 0, 10);
    send_ray(0, 5, 7);
    send_ray(-262144, -262144, 262143);
    send_ray(262143, -262144, -262144);
    for (int i = 0; i < 25; i++) send_ray(rnd_full(), rnd_full(), rnd_full());
    for (int i = 0; i < 25; i++)
      send_ray(longint'($urandom_range(0, 40)) - 20, longint'($urandom_range(0, 40)) - 20,
               longint'($urandom_range(0, 40)) - 20);
    drain();

    // Back-pressure: hold out_ready low, wiggle in_valid, then release.
    force_low = 1'b1;
    send_ray(3, 7, 2);
    waited = 0;
    while (!out_valid_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("out_valid_timeout", 0, 1);
    repeat (5) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_scalar = W'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    force_low = 1'b0;
    send_ray(2, -9, 4);
    drain();

    // Reset after two beats discards them.
    send_beat(9, waited);
    send_beat(9, waited);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready_a, 0);
    check("mid_rst_out_valid", out_valid_a, 0);
    check("mid_rst_out_disc", out_disc_a, 0);
    check("mid_rst_out_hit", out_hit_a, 0);
`ifdef RAY_HIT_COUNT_EN
    check("mid_rst_hit_count", hit_count_a, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send_ray(1, 2, 3);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
